// File: rtl/mymulfp_axil_slave.sv
// AXI4-Lite register front-end for the single-precision FP multiplier core.
// Holds operands, control/status and result; pulses mul_start and captures
// the core's result and flags on mul_done.
module mymulfp_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [31:0]                     mul_a,
   output logic [31:0]                     mul_b,
   output logic                            mul_start,
   input  logic                            mul_done,
   input  logic [31:0]                     mul_result,
   input  logic [3:0]                      mul_flags
);

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   localparam logic [1:0] REG_OPA     = 2'd0;
   localparam logic [1:0] REG_OPB     = 2'd1;
   localparam logic [1:0] REG_CTRL    = 2'd2;
   localparam logic [1:0] REG_RESULT  = 2'd3;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   w_state_t    w_state, w_state_nxt;
   r_state_t    r_state, r_state_nxt;

   logic        aw_held, w_held;
   logic [1:0]  aw_sel_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        aw_hs, w_hs, ar_hs, wr_fire;
   logic [1:0]  wr_sel;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;

   logic [31:0] opa, opb, result;
   logic [3:0]  flags;
   logic        busy, done, start_q;
   logic [1:0]  bresp_q;
   logic [31:0] rdata_q, rd_mux;
   logic        cpl, busy_eff;

   logic        unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int unsigned i = 0; i < 4; i++) begin
         if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
   assign wr_sel   = aw_held ? aw_sel_q : S_AXI_AWADDR[3:2];
   assign wr_data  = w_held ? wdata_q : S_AXI_WDATA;
   assign wr_strb  = w_held ? wstrb_q : S_AXI_WSTRB;
   assign cpl      = mul_done && busy;
   assign busy_eff = busy && !mul_done;

   // Write channel: readies, response valid and next state
   always_comb begin
      w_state_nxt   = w_state;
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      wr_fire       = 1'b0;
      unique case (w_state)
         W_IDLE: begin
            S_AXI_AWREADY = !aw_held && !S_AXI_ARESET;
            S_AXI_WREADY  = !w_held && !S_AXI_ARESET;
            if ((aw_held || S_AXI_AWVALID) && (w_held || S_AXI_WVALID) && !S_AXI_ARESET) begin
               wr_fire     = 1'b1;
               w_state_nxt = W_RESP;
            end
         end
         W_RESP: begin
            S_AXI_BVALID = 1'b1;
            if (S_AXI_BREADY) w_state_nxt = W_IDLE;
         end
      endcase
   end

   // Write state register
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) w_state <= W_IDLE;
      else              w_state <= w_state_nxt;
   end

   // Hold whichever of AW / W arrives first until its partner shows up
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_sel_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else if (wr_fire) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_sel_q <= S_AXI_AWADDR[3:2];
         end
         if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
         end
      end
   end

   // Read channel: address ready, data valid and next state
   always_comb begin
      r_state_nxt   = r_state;
      S_AXI_ARREADY = 1'b0;
      S_AXI_RVALID  = 1'b0;
      unique case (r_state)
         R_IDLE: begin
            S_AXI_ARREADY = !S_AXI_ARESET;
            if (S_AXI_ARVALID) r_state_nxt = R_DATA;
         end
         R_DATA: begin
            S_AXI_RVALID = 1'b1;
            if (S_AXI_RREADY) r_state_nxt = R_IDLE;
         end
      endcase
   end

   // Register read multiplexer
   always_comb begin
      rd_mux = result;
      case (S_AXI_ARADDR[3:2])
         REG_OPA:  rd_mux = opa;
         REG_OPB:  rd_mux = opb;
         REG_CTRL: rd_mux = {24'b0, flags, 2'b0, done, busy};
         default:  rd_mux = result;
      endcase
   end

   // Read state register and read data capture (pre-update register values)
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_state <= R_IDLE;
         rdata_q <= '0;
      end else begin
         r_state <= r_state_nxt;
         if (ar_hs) rdata_q <= rd_mux;
      end
   end

   // Register file, core handshake and write response code.
   // Completion is assigned before the write so a same-cycle CTRL write wins:
   // a start restarts the core and a W1C clears the freshly set done.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         opa     <= '0;
         opb     <= '0;
         result  <= '0;
         flags   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         start_q <= 1'b0;
         bresp_q <= RESP_OKAY;
      end else begin
         start_q <= 1'b0;
         if (cpl) begin
            result <= mul_result;
            flags  <= mul_flags;
            busy   <= 1'b0;
            done   <= 1'b1;
         end
         if (wr_fire) begin
            bresp_q <= RESP_OKAY;
            case (wr_sel)
               REG_OPA: begin
                  if (busy_eff) bresp_q <= RESP_SLVERR;
                  else          opa <= strb_merge(opa, wr_data, wr_strb);
               end
               REG_OPB: begin
                  if (busy_eff) bresp_q <= RESP_SLVERR;
                  else          opb <= strb_merge(opb, wr_data, wr_strb);
               end
               REG_CTRL: begin
                  if (wr_data[1]) done <= 1'b0;
                  if (wr_data[0]) begin
                     if (busy_eff) begin
                        bresp_q <= RESP_SLVERR;
                     end else begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        start_q <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign S_AXI_BRESP = bresp_q;
   assign S_AXI_RDATA = rdata_q;
   assign S_AXI_RRESP = 2'b00;
   assign mul_a       = opa;
   assign mul_b       = opb;
   assign mul_start   = start_q;

endmodule

// File: tb/tb_mymulfp_axil_slave.sv
// Self-checking bench for mymulfp_axil_slave: directed register-map scenarios
// followed by randomized AXI traffic, all checked every cycle against a
// transaction-level model of the register block.
module tb_mymulfp_axil_slave;

   logic        aclk = 1'b0;
   logic        areset;
   logic [3:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;
   logic [31:0] mul_a, mul_b;
   logic        mul_start, mul_done;
   logic [31:0] mul_result;
   logic [3:0]  mul_flags;

   always #5 aclk = ~aclk;

   mymulfp_axil_slave #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(4)
   ) dut (
      .S_AXI_ACLK    (aclk),
      .S_AXI_ARESET  (areset),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .mul_a         (mul_a),
      .mul_b         (mul_b),
      .mul_start     (mul_start),
      .mul_done      (mul_done),
      .mul_result    (mul_result),
      .mul_flags     (mul_flags)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // model of the register block and its two AXI channels
   logic [31:0] m_opa, m_opb, m_result, m_rdata;
   logic [3:0]  m_flags;
   logic        m_busy, m_done, m_start;
   logic        m_b_valid, m_r_valid;
   logic [1:0]  m_bresp;
   logic        m_aw_got, m_w_got;
   logic [1:0]  m_aw_sel;
   logic [31:0] m_wd;
   logic [3:0]  m_ws;
   logic        m_aw_acc, m_w_acc, m_ar_acc;

   // environment state
   bit          rand_mode = 1'b0;
   int          rst_left = 0;
   int          core_cnt = 0;
   int          core_lat = 5;
   logic [31:0] core_res = 32'h0;
   logic [3:0]  core_flg = 4'h0;
   int          start_pulses = 0;
   logic        start_at_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] sel);
      case (sel)
         2'd0:    return m_opa;
         2'd1:    return m_opb;
         2'd2:    return {24'h0, m_flags, 2'b00, m_done, m_busy};
         default: return m_result;
      endcase
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] d,
                                              input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (old_v & ~mask) | (d & mask);
   endfunction

   task automatic model_step();
      logic fire, busy_e;
      m_aw_acc = 1'b0;
      m_w_acc  = 1'b0;
      m_ar_acc = 1'b0;
      if (areset) begin
         m_opa = '0; m_opb = '0; m_result = '0; m_rdata = '0; m_flags = '0;
         m_busy = 1'b0; m_done = 1'b0; m_start = 1'b0;
         m_b_valid = 1'b0; m_r_valid = 1'b0; m_bresp = 2'b00;
         m_aw_got = 1'b0; m_w_got = 1'b0;
         return;
      end
      m_start = 1'b0;
      // reads see the registers as they were before this edge
      if (m_r_valid) begin
         if (rready) m_r_valid = 1'b0;
      end else if (arvalid) begin
         m_ar_acc  = 1'b1;
         m_rdata   = model_read(araddr[3:2]);
         m_r_valid = 1'b1;
      end
      fire = 1'b0;
      if (m_b_valid) begin
         if (bready) m_b_valid = 1'b0;
      end else begin
         if (!m_aw_got && awvalid) begin
            m_aw_acc = 1'b1; m_aw_got = 1'b1; m_aw_sel = awaddr[3:2];
         end
         if (!m_w_got && wvalid) begin
            m_w_acc = 1'b1; m_w_got = 1'b1; m_wd = wdata; m_ws = wstrb;
         end
         if (m_aw_got && m_w_got) begin
            fire = 1'b1; m_aw_got = 1'b0; m_w_got = 1'b0;
         end
      end
      if (mul_done && m_busy) begin
         m_result = mul_result; m_flags = mul_flags; m_busy = 1'b0; m_done = 1'b1;
      end
      if (fire) begin
         busy_e    = m_busy;
         m_bresp   = 2'b00;
         m_b_valid = 1'b1;
         case (m_aw_sel)
            2'd0: if (busy_e) m_bresp = 2'b10; else m_opa = byte_merge(m_opa, m_wd, m_ws);
            2'd1: if (busy_e) m_bresp = 2'b10; else m_opb = byte_merge(m_opb, m_wd, m_ws);
            2'd2: begin
               if (m_wd[1]) m_done = 1'b0;
               if (m_wd[0]) begin
                  if (busy_e) m_bresp = 2'b10;
                  else begin m_busy = 1'b1; m_done = 1'b0; m_start = 1'b1; end
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_outputs();
      chk("awready",   awready,   !areset && !m_b_valid && !m_aw_got);
      chk("wready",    wready,    !areset && !m_b_valid && !m_w_got);
      chk("arready",   arready,   !areset && !m_r_valid);
      chk("bvalid",    bvalid,    m_b_valid);
      chk("bresp",     bresp,     m_bresp);
      chk("rvalid",    rvalid,    m_r_valid);
      chk("rdata",     rdata,     m_rdata);
      chk("rresp",     rresp,     2'b00);
      chk("mul_start", mul_start, m_start);
      chk("mul_a",     mul_a,     m_opa);
      chk("mul_b",     mul_b,     m_opb);
   endtask

   task automatic core_drive();
      mul_done = 1'b0;
      if (mul_start) begin
         core_cnt = rand_mode ? $urandom_range(1, 8) : core_lat;
      end else if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) begin
            mul_done   = 1'b1;
            mul_result = rand_mode ? $urandom : core_res;
            mul_flags  = rand_mode ? 4'($urandom) : core_flg;
         end
      end else if (rand_mode && $urandom_range(0, 29) == 0) begin
         mul_done   = 1'b1;
         mul_result = $urandom;
         mul_flags  = 4'($urandom);
      end
   endtask

   task automatic master_update();
      if (awvalid && m_aw_acc) awvalid = 1'b0;
      if (wvalid && m_w_acc)   wvalid  = 1'b0;
      if (arvalid && m_ar_acc) arvalid = 1'b0;
      if (rand_mode) begin
         if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) areset = 1'b0;
         end else if ($urandom_range(0, 599) == 0) begin
            areset   = 1'b1;
            rst_left = $urandom_range(1, 3);
         end
         if (!areset) begin
            if (!awvalid && $urandom_range(0, 3) == 0) begin
               awvalid = 1'b1; awaddr = 4'($urandom_range(0, 15));
            end
            if (!wvalid && $urandom_range(0, 3) == 0) begin
               wvalid = 1'b1;
               wdata  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
               wstrb  = 4'($urandom_range(0, 15));
            end
            if (!arvalid && $urandom_range(0, 2) == 0) begin
               arvalid = 1'b1; araddr = 4'($urandom_range(0, 15));
            end
            bready = ($urandom_range(0, 2) != 0);
            rready = ($urandom_range(0, 2) != 0);
         end
      end
      if (areset) begin
         awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge aclk);
      model_step();
      @(negedge aclk);
      check_outputs();
      if (mul_start) start_pulses++;
      core_drive();
      master_update();
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bdly, output logic [1:0] resp);
      int n;
      bready  = 1'b0;
      awaddr  = a;
      awvalid = 1'b1;
      for (int i = 0; i < lead; i++) begin
         step();
         chk("awready_after_aw", awready, 1'b0);
         chk("wready_waiting", wready, 1'b1);
      end
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      n = 0;
      while (!bvalid && n < 50) begin
         step();
         n++;
      end
      chk("bvalid_wait", bvalid, 1'b1);
      start_at_b = mul_start;
      for (int i = 0; i < bdly; i++) begin
         step();
         chk("bvalid_held", bvalid, 1'b1);
         chk("awready_in_resp", awready, 1'b0);
      end
      resp   = bresp;
      bready = 1'b1;
      step();
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] a, input int rdly, output logic [31:0] d);
      int n;
      rready  = 1'b0;
      araddr  = a;
      arvalid = 1'b1;
      n = 0;
      while (!rvalid && n < 50) begin
         step();
         n++;
      end
      chk("rvalid_wait", rvalid, 1'b1);
      d = rdata;
      for (int i = 0; i < rdly; i++) begin
         step();
         chk("rvalid_held", rvalid, 1'b1);
         chk("arready_in_data", arready, 1'b0);
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0]  r;
      logic [31:0] d;
      int          p0;
      areset = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      mul_done = 1'b0; mul_result = '0; mul_flags = '0;

      repeat (3) step();
      chk("reset_awready", awready, 1'b0);
      chk("reset_arready", arready, 1'b0);
      chk("reset_mul_start", mul_start, 1'b0);
      areset = 1'b0;
      step();

      // operand write/readback
      axi_write(4'h0, 32'h3FC00000, 4'hF, 0, 0, r); chk("t1_bresp_opa", r, 2'b00);
      axi_write(4'h4, 32'h40000000, 4'hF, 0, 0, r); chk("t1_bresp_opb", r, 2'b00);
      axi_read(4'h0, 0, d); chk("t1_read_opa", d, 32'h3FC00000);
      axi_read(4'h4, 0, d); chk("t1_read_opb", d, 32'h40000000);

      // start, completion, W1C
      core_lat = 5; core_res = 32'h40400000; core_flg = 4'h0;
      chk("t2_start_before", mul_start, 1'b0);
      p0 = start_pulses;
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, r);
      chk("t2_bresp", r, 2'b00);
      chk("t2_start_at_t1", start_at_b, 1'b1);
      axi_read(4'h8, 0, d); chk("t2_ctrl_busy", d, 32'h1);
      chk("t2_one_pulse", start_pulses - p0, 1);
      repeat (10) step();
      axi_read(4'hC, 0, d); chk("t2_result", d, 32'h40400000);
      axi_read(4'h8, 0, d); chk("t2_ctrl_done", d, 32'h2);
      axi_write(4'h8, 32'h2, 4'hF, 0, 0, r);
      axi_read(4'h8, 0, d); chk("t2_ctrl_cleared", d, 32'h0);

      // writes while busy
      core_lat = 20;
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, r); chk("t3_start_ok", r, 2'b00);
      axi_write(4'h0, 32'h5, 4'hF, 0, 0, r); chk("t3_opa_slverr", r, 2'b10);
      axi_read(4'h0, 0, d); chk("t3_opa_kept", d, 32'h3FC00000);
      p0 = start_pulses;
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, r); chk("t3_start_slverr", r, 2'b10);
      step();
      chk("t3_no_pulse", start_pulses - p0, 0);
      repeat (25) step();

      // byte strobes
      axi_write(4'h0, 32'h11223344, 4'hF, 0, 0, r);
      axi_write(4'h0, 32'hAABBCCDD, 4'h3, 0, 0, r); chk("t4_bresp", r, 2'b00);
      axi_read(4'h0, 0, d); chk("t4_strobe_merge", d, 32'h1122CCDD);

      // AW ahead of W, B and R stalls
      axi_write(4'h4, 32'hCAFEF00D, 4'hF, 3, 4, r); chk("t5_bresp", r, 2'b00);
      axi_read(4'h4, 4, d); chk("t5_read_stalled", d, 32'hCAFEF00D);

      // completion coincides with a W1C write
      core_lat = 1; core_res = 32'h12345678; core_flg = 4'hA;
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, r);
      axi_write(4'h8, 32'h2, 4'hF, 0, 0, r); chk("t7_w1c_bresp", r, 2'b00);
      axi_read(4'h8, 0, d); chk("t7_ctrl", d, 32'h000000A0);
      axi_read(4'hC, 0, d); chk("t7_result", d, 32'h12345678);

      // completion coincides with a restart
      p0 = start_pulses;
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, r);
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, r); chk("t8_restart_bresp", r, 2'b00);
      repeat (5) step();
      chk("t8_two_pulses", start_pulses - p0, 2);
      axi_read(4'h8, 0, d); chk("t8_ctrl", d, 32'h000000A2);

      // reset during an operation
      core_lat = 6; core_res = 32'hDEADBEEF; core_flg = 4'hF;
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, r);
      step();
      areset = 1'b1;
      step();
      chk("t6_rst_awready", awready, 1'b0);
      step();
      areset = 1'b0;
      repeat (10) step();
      axi_read(4'h8, 0, d); chk("t6_ctrl_zero", d, 32'h0);
      axi_read(4'hC, 0, d); chk("t6_result_zero", d, 32'h0);

      // randomized traffic
      rand_mode = 1'b1;
      repeat (3000) step();
      rand_mode = 1'b0;
      areset = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
